// File: rtl/mem_arb2.sv
// mem_arb2 -- two-requester round-robin arbiter in front of one shared slave
// port (for example a PSRAM controller).
//
// A requester raises mN_valid_i with address/data/strobes and holds them until
// its one-cycle mN_ready_o completion pulse. The arbiter grants one requester
// at a time, forwards its request to the slave port, and returns the slave
// response. If the slave stays silent for TIMEOUT_CYC BUSY cycles, the
// transaction is aborted. The aborted requester then gets ERR_RDATA and the
// sticky timeout flag is raised.
//
// Parameters
//   TIMEOUT_CYC   max slave-response wait in BUSY cycles (1..255)
//   ERR_RDATA     read data returned on a timeout abort
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   m0_*/m1_* valid/addr/wdata/wstrb requester requests (wstrb == 0 is a read)
//   m0_*/m1_* rdata/ready            requester responses
//   s_valid/addr/wdata/wstrb_o       shared slave request
//   s_rdata_i, s_ready_i             shared slave response
//   grant_o                          owning requester index (valid while busy_o)
//   busy_o                           arbiter is in BUSY
//   timeout_o, clr_timeout_i         sticky timeout flag and its clear
module mem_arb2 #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ready_i,
  output logic        grant_o,
  output logic        busy_o,
  output logic        timeout_o,
  input  logic        clr_timeout_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t      state_r;
  state_t      state_next_s;
  logic        grant_r;
  logic        grant_next_s;
  logic        last_grant_r;
  logic        last_grant_next_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_next_s;
  logic [7:0]  cnt_inc_s;
  logic        timeout_r;
  logic        timeout_set_s;
  logic        gnt_valid_s;
  logic        resp_s;
  logic [31:0] resp_data_s;

  // Valid of whichever requester currently owns the slave port.
  assign gnt_valid_s = grant_r ? m1_valid_i : m0_valid_i;

  // Saturating increment so the wait counter can never wrap.
  assign cnt_inc_s = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);

  // Next-state, slave-port mux and completion response.
  always_comb begin
    state_next_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    cnt_next_s        = cnt_r;
    timeout_set_s     = 1'b0;
    resp_s            = 1'b0;
    resp_data_s       = 32'h0000_0000;
    s_valid_o         = 1'b0;
    s_addr_o          = 32'h0000_0000;
    s_wdata_o         = 32'h0000_0000;
    s_wstrb_o         = 4'h0;

    case (state_r)
      ST_IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          // On a tie the requester that did not finish last wins.
          if (m0_valid_i && m1_valid_i) begin
            grant_next_s = ~last_grant_r;
          end else begin
            grant_next_s = m1_valid_i;
          end
          cnt_next_s   = 8'd0;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        s_valid_o = gnt_valid_s;
        s_addr_o  = grant_r ? m1_addr_i  : m0_addr_i;
        s_wdata_o = grant_r ? m1_wdata_i : m0_wdata_i;
        s_wstrb_o = grant_r ? m1_wstrb_i : m0_wstrb_i;
        if (!gnt_valid_s) begin
          // Requester withdrew: drop the transaction silently, keep fairness state.
          state_next_s = ST_IDLE;
        end else if (s_ready_i) begin
          resp_s            = 1'b1;
          resp_data_s       = s_rdata_i;
          last_grant_next_s = grant_r;
          state_next_s      = ST_IDLE;
        end else begin
          cnt_next_s = cnt_inc_s;
          if (cnt_inc_s >= TIMEOUT_LIM) begin
            // The timeout event spans this edge and the ABORT cycle, so a
            // clear request in either cycle cannot override it.
            timeout_set_s = 1'b1;
            state_next_s  = ST_ABORT;
          end else begin
            state_next_s = ST_BUSY;
          end
        end
      end

      ST_ABORT: begin
        resp_s            = 1'b1;
        resp_data_s       = ERR_RDATA;
        timeout_set_s     = 1'b1;
        last_grant_next_s = grant_r;
        state_next_s      = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Route the completion to the granted requester only; the other sees zeros.
  assign m0_ready_o = resp_s & ~grant_r;
  assign m1_ready_o = resp_s &  grant_r;
  assign m0_rdata_o = (resp_s && !grant_r) ? resp_data_s : 32'h0000_0000;
  assign m1_rdata_o = (resp_s &&  grant_r) ? resp_data_s : 32'h0000_0000;

  assign grant_o   = grant_r;
  assign busy_o    = (state_r == ST_BUSY);
  assign timeout_o = timeout_r;

  // State, grant bookkeeping, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= 8'd0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
      cnt_r        <= cnt_next_s;
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end else if (clr_timeout_i) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Testbench for mem_arb2 (TIMEOUT_CYC = 4). A stimulus thread drives directed
// vectors and queues the expected completion for each transaction. A monitor
// pops and compares on every mN_ready_o pulse.
module tb_mem_arb2;

  logic        clk;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        grant, busy, timeout, clr_timeout;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  mem_arb2 #(.TIMEOUT_CYC(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .m0_valid_i   (m0_valid),
    .m0_addr_i    (m0_addr),
    .m0_wdata_i   (m0_wdata),
    .m0_wstrb_i   (m0_wstrb),
    .m0_rdata_o   (m0_rdata),
    .m0_ready_o   (m0_ready),
    .m1_valid_i   (m1_valid),
    .m1_addr_i    (m1_addr),
    .m1_wdata_i   (m1_wdata),
    .m1_wstrb_i   (m1_wstrb),
    .m1_rdata_o   (m1_rdata),
    .m1_ready_o   (m1_ready),
    .s_valid_o    (s_valid),
    .s_addr_o     (s_addr),
    .s_wdata_o    (s_wdata),
    .s_wstrb_o    (s_wstrb),
    .s_rdata_i    (s_rdata),
    .s_ready_i    (s_ready),
    .grant_o      (grant),
    .busy_o       (busy),
    .timeout_o    (timeout),
    .clr_timeout_i(clr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic who, input logic [31:0] d);
    exp_q.push_back({who, d});
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (m0_ready || m1_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: m0_ready=%0b m1_ready=%0b, want no pulse (t=%0t)",
                 m0_ready, m1_ready, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_ready", {30'd0, m1_ready, m0_ready}, mon_e.who ? 32'd2 : 32'd1);
        chk("resp_rdata", mon_e.who ? m1_rdata : m0_rdata, mon_e.data);
        chk("other_rdata", mon_e.who ? m0_rdata : m1_rdata, 32'h0000_0000);
      end
    end
  end

  initial begin
    rst = 1'b1; clr_timeout = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_rdata = 32'h0; s_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_grant",   32'(grant),    32'd0);
    chk("rst_timeout", 32'(timeout),  32'd0);
    chk("rst_svalid",  32'(s_valid),  32'd0);
    chk("rst_ready",   {30'd0, m1_ready, m0_ready}, 32'd0);
    tick(); rst = 1'b0;

    // m0 read of 0x100, slave answers 3 cycles after s_valid
    tick(); m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
    @(negedge clk);
    chk("rd_idle_busy",   32'(busy),    32'd0);
    chk("rd_idle_svalid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_svalid", 32'(s_valid), 32'd1);
    chk("rd_saddr",  s_addr,        32'h0000_0100);
    chk("rd_swstrb", 32'(s_wstrb),  32'd0);
    chk("rd_grant",  32'(grant),    32'd0);
    chk("rd_busy",   32'(busy),     32'd1);
    tick(); tick();
    tick(); s_ready = 1'b1; s_rdata = 32'h1234_5678; expect_resp(1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("rd_m1_ready", 32'(m1_ready), 32'd0);
    tick(); s_ready = 1'b0; m0_valid = 1'b0;
    @(negedge clk);
    chk("rd_done_busy", 32'(busy), 32'd0);

    // Both requesters valid straight after reset: m0, m1, m0 with IDLE gaps
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick(); m0_valid = 1'b1; m0_addr = 32'h0000_00A0; m1_valid = 1'b1; m1_addr = 32'h0000_00B0;
    @(negedge clk);
    chk("rr_first_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); s_ready = 1'b1; s_rdata = 32'h0A0A_0000 + 32'(i);
      expect_resp(i == 1, 32'h0A0A_0000 + 32'(i));
      @(negedge clk);
      chk("rr_grant", 32'(grant), (i == 1) ? 32'd1 : 32'd0);
      chk("rr_saddr", s_addr, (i == 1) ? 32'h0000_00B0 : 32'h0000_00A0);
      chk("rr_busy",  32'(busy), 32'd1);
      tick(); s_ready = 1'b0;
      if (i == 2) begin
        m0_valid = 1'b0; m1_valid = 1'b0;
      end
      @(negedge clk);
      chk("rr_gap_idle", 32'(busy), 32'd0);
    end

    // m1 write, slave silent: ABORT after 4 BUSY cycles
    tick(); m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF;
    tick();
    @(negedge clk);
    chk("to_svalid", 32'(s_valid), 32'd1);
    chk("to_saddr",  s_addr,       32'h0000_0200);
    chk("to_swdata", s_wdata,      32'hCAFE_0001);
    chk("to_swstrb", 32'(s_wstrb), 32'hF);
    chk("to_grant",  32'(grant),   32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("to_busy_c4", 32'(busy), 32'd1);
    tick(); s_ready = 1'b1; s_rdata = 32'h5555_5555; expect_resp(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("abort_busy",   32'(busy),    32'd0);
    chk("abort_svalid", 32'(s_valid), 32'd0);
    tick(); m1_valid = 1'b0;
    @(negedge clk);
    chk("to_flag",      32'(timeout), 32'd1);
    chk("late_rdy_idle", {30'd0, m1_ready, m0_ready}, 32'd0);
    tick(); s_ready = 1'b0; clr_timeout = 1'b1;
    @(negedge clk);
    chk("to_sticky", 32'(timeout), 32'd1);
    tick(); clr_timeout = 1'b0;
    @(negedge clk);
    chk("to_cleared", 32'(timeout), 32'd0);

    // Granted m0 withdraws in BUSY; pending m1 is served next
    tick(); m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
    tick(); m1_valid = 1'b1; m1_addr = 32'h0000_0500; m1_wstrb = 4'h0;
    @(negedge clk);
    chk("drop_grant0", 32'(grant), 32'd0);
    chk("drop_busy",   32'(busy),  32'd1);
    tick(); m0_valid = 1'b0;
    @(negedge clk);
    chk("drop_svalid", 32'(s_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("drop_idle", 32'(busy), 32'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'h0000_0077; expect_resp(1'b1, 32'h0000_0077);
    @(negedge clk);
    chk("drop_grant1", 32'(grant), 32'd1);
    chk("drop_saddr",  s_addr,     32'h0000_0500);
    tick(); s_ready = 1'b0; m1_valid = 1'b0;

    // Timeout with clr_timeout held through the whole transaction: set wins
    tick(); m0_valid = 1'b1; m0_addr = 32'h0000_0300; clr_timeout = 1'b1;
    tick(); tick(); tick(); tick();
    tick(); expect_resp(1'b0, 32'hDEAD_BEEF);
    tick(); m0_valid = 1'b0; clr_timeout = 1'b0;
    @(negedge clk);
    chk("set_wins", 32'(timeout), 32'd1);

    // Asynchronous reset in mid-BUSY, then a late slave ready
    tick(); m1_valid = 1'b1; m1_addr = 32'h0000_0600;
    tick();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1; rst = 1'b1; s_ready = 1'b1; s_rdata = 32'h0000_0099; m1_valid = 1'b0;
    #1;
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_grant",   32'(grant),   32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_svalid",  32'(s_valid), 32'd0);
    chk("arst_saddr",   s_addr,       32'h0000_0000);
    chk("arst_ready",   {30'd0, m1_ready, m0_ready}, 32'd0);
    tick(); rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("post_rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("post_rst_busy",  32'(busy), 32'd0);
    tick(); s_ready = 1'b0;
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
